// File: rtl/coord_mult_gen.sv
// coord_mult_gen: produces the 19 signed multiples k*c (k = 0..18) of one orientation coefficient with a single shared adder
// Ports: clk, rst_n (async active-low); start/coef_in/in_ready accept a coefficient;
//        out_valid/out_ready hand off mult_out (19 x BW_XCOS, slice k = k*c, k=0 at LSBs).
// Macro COORD_MULT_SAT_EN: saturate each multiple to +/-(2^(BW_XCOS-1)-1) instead of wrapping.
module coord_mult_gen #(
  parameter int BW_COS  = 12,
  parameter int BW_XCOS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BW_COS-1:0]      coef_in,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [19*BW_XCOS-1:0]  mult_out
);
  localparam int AW = BW_XCOS + 5;
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  state_t                    state;
  logic signed [BW_COS-1:0]  coef_r;
  logic signed [AW-1:0]      acc;
  logic [4:0]                k;
  logic [BW_XCOS-1:0]        res [19];
  logic [BW_XCOS-1:0]        fit_acc;
`ifdef COORD_MULT_SAT_EN
  localparam logic signed [AW-1:0] SMAX = AW'((1 << (BW_XCOS - 1)) - 1);
  localparam logic signed [AW-1:0] SMIN = -SMAX;
  // symmetric clamp keeps the downstream negation overflow-free
  always_comb fit_acc = acc > SMAX ? SMAX[BW_XCOS-1:0] : acc < SMIN ? SMIN[BW_XCOS-1:0] : acc[BW_XCOS-1:0];
`else
  always_comb fit_acc = acc[BW_XCOS-1:0];
`endif
  for (genvar i = 0; i < 19; i++) begin : g_out
    assign mult_out[i*BW_XCOS +: BW_XCOS] = res[i];
  end
  // acc lags the write index by one step, so res[k] receives k*c and res[0] gets 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      coef_r    <= '0;
      acc       <= '0;
      k         <= '0;
      for (int j = 0; j < 19; j++) res[j] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          coef_r   <= coef_in;
          acc      <= '0;
          k        <= '0;
          in_ready <= 1'b0;
          state    <= ACC;
        end
        ACC: begin
          res[k] <= fit_acc;
          acc    <= acc + AW'(coef_r);
          k      <= k + 5'd1;
          if (k == 5'd18) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_coord_mult_gen.sv
// tb_coord_mult_gen: directed self-checking bench for coord_mult_gen
module tb_coord_mult_gen;
  localparam int W = 16;
  logic            clk = 0, rst_n = 0, start = 0, out_ready = 0;
  logic [11:0]     coef_in = '0;
  logic            in_ready, out_valid;
  logic [19*W-1:0] mult_out;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  coord_mult_gen #(.BW_COS(12), .BW_XCOS(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .coef_in(coef_in),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .mult_out(mult_out)
  );

  function automatic int sl(input int k);
    logic [W-1:0] v;
    v = mult_out[k*W +: W];
    return int'($signed(v));
  endfunction

  task automatic wait_valid(input string tag);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (out_valid === 1'b1) ok = 1;
      else @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s timeout: out_valid=%b required 1", tag, out_valid); end
  endtask

  task automatic launch(input int c, input string tag);
    @(negedge clk); start = 1; coef_in = 12'(c);
    @(negedge clk); start = 0; coef_in = 12'h5a5;
    wait_valid(tag);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1;
    @(negedge clk); out_ready = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s handshake: out_valid=%b in_ready=%b required 0/1", tag, out_valid, in_ready);
    end
  endtask

  task automatic chk(input string tag, input int k, input int exp);
    checks++;
    if (sl(k) !== exp) begin errors++; $display("FAIL %s slice%0d: got %0d required %0d", tag, k, sl(k), exp); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || mult_out !== '0) begin
      errors++; $display("FAIL reset: in_ready=%b out_valid=%b bus=%h required 1/0/0", in_ready, out_valid, mult_out);
    end
  endtask

  task automatic test_unit();
    int first = 0, vcnt = 0, lo = 0;
    out_ready = 1;
    @(negedge clk); start = 1; coef_in = 12'd1024;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 0; coef_in = 12'd0; end
      if (!in_ready) lo++;
      if (out_valid) begin vcnt++; if (first == 0) first = c; end
    end
    out_ready = 0;
    checks++;
    if (first != 20) begin errors++; $display("FAIL unit latency: got %0d required 20", first); end
    checks++;
    if (vcnt != 1) begin errors++; $display("FAIL unit valid_len: got %0d required 1", vcnt); end
    checks++;
    if (lo != 20) begin errors++; $display("FAIL unit in_ready_low: got %0d required 20", lo); end
    for (int k = 0; k < 19; k++) chk("unit", k, 1024 * k);
  endtask

  task automatic test_neg();
    launch(-724, "neg");
    chk("neg", 0, 0);
    chk("neg", 1, -724);
    chk("neg", 13, -9412);
    chk("neg", 18, -13032);
    release_out("neg");
  endtask

  task automatic test_sat();
    launch(2047, "sat");
    chk("sat", 16, 32752);
`ifdef COORD_MULT_SAT_EN
    chk("sat", 17, 32767);
    chk("sat", 18, 32767);
`else
    chk("sat", 17, -30737);
    chk("sat", 18, -28690);
`endif
    release_out("sat");
  endtask

  task automatic test_backpressure();
    logic [19*W-1:0] exp;
    for (int k = 0; k < 19; k++) exp[k*W +: W] = W'(250 * k);
    @(negedge clk); start = 1; coef_in = 12'd250;
    @(negedge clk); coef_in = 12'd500;
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || mult_out !== exp) begin
        errors++; $display("FAIL bp stall%0d: out_valid=%b slice18=%0d required 1/4500", i, out_valid, sl(18));
      end
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk); out_ready = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || mult_out !== exp) begin
      errors++; $display("FAIL bp idle: out_valid=%b in_ready=%b slice18=%0d required 0/1/4500", out_valid, in_ready, sl(18));
    end
    @(negedge clk); start = 0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp accept: in_ready=%b required 0", in_ready); end
    wait_valid("bp2");
    chk("bp2", 1, 500);
    chk("bp2", 18, 9000);
    release_out("bp2");
  endtask

  task automatic test_reset_mid();
    @(negedge clk); start = 1; coef_in = 12'd700;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 0;
    end
    rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || mult_out !== '0) begin
      errors++; $display("FAIL rstmid async: out_valid=%b in_ready=%b slice18=%0d required 0/1/0", out_valid, in_ready, sl(18));
    end
    @(negedge clk); rst_n = 1;
    launch(100, "rstmid");
    chk("rstmid", 9, 900);
    chk("rstmid", 18, 1800);
    release_out("rstmid");
  endtask

  task automatic test_back_to_back();
    int acc_at[$];
    int exp_q[$];
    bit neg = 0;
    int nres = 0;
    out_ready = 1;
    start = 1;
    for (int c = 0; c < 70; c++) begin
      if (in_ready) begin
        acc_at.push_back(c);
        coef_in = neg ? -12'sd300 : 12'sd300;
        exp_q.push_back(neg ? -5400 : 5400);
        neg = !neg;
      end
      if (out_valid && exp_q.size() > 0) begin
        nres++;
        chk("b2b", 18, exp_q.pop_front());
      end
      @(negedge clk);
    end
    start = 0;
    out_ready = 0;
    checks++;
    if (acc_at.size() != 4) begin errors++; $display("FAIL b2b accepts: got %0d required 4", acc_at.size()); end
    for (int i = 1; i < acc_at.size(); i++) begin
      checks++;
      if (acc_at[i] - acc_at[i-1] != 21) begin
        errors++; $display("FAIL b2b period%0d: got %0d required 21", i, acc_at[i] - acc_at[i-1]);
      end
    end
    checks++;
    if (nres != 3) begin errors++; $display("FAIL b2b results: got %0d required 3", nres); end
  endtask

  initial begin
    test_reset();
    test_unit();
    test_neg();
    test_sat();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
